// File: rtl/display_scan_decoder_if.sv
// Bundle of the scanned display bus and the decoded frame outputs.
// The slave side is the decoder; the master side drives the bus and observes the frames.
interface display_scan_decoder_if;
  logic [13:0] disp_bus;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [1:0]  leds;
  logic        frame_valid;
  logic        frame_chg;
  logic        seg_err;
  logic        an_err;
  logic        timeout;

  modport master (
    output disp_bus,
    input  digits, dps, leds, frame_valid, frame_chg, seg_err, an_err, timeout
  );

  modport slave (
    input  disp_bus,
    output digits, dps, leds, frame_valid, frame_chg, seg_err, an_err, timeout
  );
endinterface

// File: rtl/display_scan_decoder.sv
// Receive-side decoder for the 14-bit scanned display bus: waits for each digit slot to
// settle, decodes its 7-segment pattern to BCD and assembles 4-digit frames.
module display_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  display_scan_decoder_if.slave        scan
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [13:0] IDLE_WORD = 14'h0FFF;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} stateT;

  stateT          state, stateNext;
  logic [13:0]    busReg;
  logic [11:0]    wordPrev;
  logic [11:0]    captureWord;
  logic [SW-1:0]  stableCnt;
  logic [TW-1:0]  frameTimer;
  logic [3:0]     mask;
  logic [15:0]    frameDigits;
  logic [3:0]     frameDps;
  logic [15:0]    digitsReg;
  logic [3:0]     dpsReg;
  logic [1:0]     ledsReg;
  logic           frameValidReg, frameChgReg, segErrReg, anErrReg, timeoutReg;
  logic           firstFrame;
  logic           wordChanged;
  logic [3:0]     anode;
  logic [1:0]     slot;
  logic           slotValid;
  logic [3:0]     capDecoded;

  function automatic logic [3:0] decodeSeg(input logic [6:0] seg);
    case (seg)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      7'h7F:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  assign anode       = busReg[11:8];
  assign wordChanged = (busReg[11:0] != wordPrev);

  // Input register plus a delayed copy of the anode+segment word for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      busReg   <= IDLE_WORD;
      wordPrev <= IDLE_WORD[11:0];
    end else begin
      busReg   <= scan.disp_bus;
      wordPrev <= busReg[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stableCnt <= '0;
    else if (wordChanged)
      stableCnt <= '0;
    else if (stableCnt != SW'(STABLE_CYCLES))
      stableCnt <= stableCnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // SETTLE also drops back to IDLE if the anodes all go inactive before the slot settles.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anode != 4'hF) stateNext = SETTLE;
      SETTLE: begin
        if (anode == 4'hF)
          stateNext = IDLE;
        else if (!wordChanged && stableCnt == SW'(STABLE_CYCLES))
          stateNext = CAPTURE;
      end
      CAPTURE: stateNext = HOLD;
      HOLD: begin
        if (anode != captureWord[11:8])
          stateNext = (anode == 4'hF) ? IDLE : SETTLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    slot      = 2'd0;
    slotValid = 1'b1;
    case (captureWord[11:8])
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slotValid = 1'b0;
    endcase
    capDecoded = decodeSeg(captureWord[6:0]);
  end

  // Frame assembly: a capture issued after the mask clears lands in the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      captureWord   <= IDLE_WORD[11:0];
      mask          <= '0;
      frameTimer    <= '0;
      frameDigits   <= 16'hFFFF;
      frameDps      <= '0;
      digitsReg     <= 16'hFFFF;
      dpsReg        <= '0;
      ledsReg       <= '0;
      frameValidReg <= 1'b0;
      frameChgReg   <= 1'b0;
      segErrReg     <= 1'b0;
      anErrReg      <= 1'b0;
      timeoutReg    <= 1'b0;
      firstFrame    <= 1'b1;
    end else begin
      frameValidReg <= 1'b0;
      frameChgReg   <= 1'b0;
      anErrReg      <= 1'b0;
      timeoutReg    <= 1'b0;

      if (state == SETTLE && stateNext == CAPTURE)
        captureWord <= busReg[11:0];

      if (mask == 4'hF) begin
        digitsReg     <= frameDigits;
        dpsReg        <= frameDps;
        ledsReg       <= busReg[13:12];
        frameValidReg <= 1'b1;
        frameChgReg   <= firstFrame || ({frameDigits, frameDps} != {digitsReg, dpsReg});
        firstFrame    <= 1'b0;
        mask          <= '0;
        frameTimer    <= '0;
        segErrReg     <= 1'b0;
      end else if (mask != 4'h0 && frameTimer == TW'(TIMEOUT)) begin
        timeoutReg <= 1'b1;
        mask       <= '0;
        frameTimer <= '0;
      end else if (mask != 4'h0) begin
        frameTimer <= frameTimer + TW'(1);
      end

      if (state == CAPTURE) begin
        if (slotValid) begin
          frameDigits[{slot, 2'b00} +: 4] <= capDecoded;
          frameDps[slot]                  <= ~captureWord[7];
          mask[slot]                      <= 1'b1;
          if (capDecoded == 4'hE)
            segErrReg <= 1'b1;
        end else begin
          anErrReg <= 1'b1;
        end
      end
    end
  end

  assign scan.digits      = digitsReg;
  assign scan.dps         = dpsReg;
  assign scan.leds        = ledsReg;
  assign scan.frame_valid = frameValidReg;
  assign scan.frame_chg   = frameChgReg;
  assign scan.seg_err     = segErrReg;
  assign scan.an_err      = anErrReg;
  assign scan.timeout     = timeoutReg;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: scans digit slots onto the bus and checks
// each latched frame against a queue of hand-computed expectations.
module tb_display_scan_decoder;

  localparam logic [13:0] IDLE_WORD = 14'h0FFF;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [1:0]  leds;
    logic        chg;
    logic        segErr;
  } frameT;

  logic  clk = 1'b0;
  logic  rst;
  frameT expQ[$];
  int    compared = 0;
  int    mismatched = 0;
  int    anErrCount = 0;
  int    timeoutCount = 0;
  logic  segErrPrev = 1'b0;

  always #5 clk = ~clk;

  display_scan_decoder_if scan();

  display_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT(65535)) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (scan.slave)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] mkWord(input logic [3:0] anode, input logic [6:0] seg,
                                         input logic dpLit, input logic [1:0] leds);
    return {leds, anode, ~dpLit, seg};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [13:0] word, input int cycles);
    scan.disp_bus = word;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectFrame(input logic [15:0] d, input logic [3:0] p, input logic [1:0] l,
                             input logic c, input logic s);
    frameT f;
    f.digits = d;
    f.dps    = p;
    f.leds   = l;
    f.chg    = c;
    f.segErr = s;
    expQ.push_back(f);
  endtask

  task automatic scanFrame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] dpLit, input logic [1:0] leds,
                           input int hold);
    logic [6:0] segs[4];
    logic [3:0] an;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    for (int k = 0; k < 4; k++) begin
      an = 4'b0001 << k;
      an = ~an;
      applyStimulus(mkWord(an, segs[k], dpLit[k], leds), hold);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput(name, 32'(expQ.size()), 0);
  endtask

  // Scoreboard monitor: every frame_valid pops one expectation.
  always @(negedge clk) begin
    frameT e;
    if (scan.frame_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFrame", 32'(scan.digits), 32'hDEAD);
      end else begin
        e = expQ.pop_front();
        checkOutput("digits", 32'(scan.digits), 32'(e.digits));
        checkOutput("dps", 32'(scan.dps), 32'(e.dps));
        checkOutput("leds", 32'(scan.leds), 32'(e.leds));
        checkOutput("frameChg", 32'(scan.frame_chg), 32'(e.chg));
        checkOutput("segErrBeforeLatch", 32'(segErrPrev), 32'(e.segErr));
      end
    end
    if (scan.an_err === 1'b1) anErrCount++;
    if (scan.timeout === 1'b1) timeoutCount++;
    segErrPrev = scan.seg_err;
  end

  initial begin
    int n;
    rst = 1'b1;
    scan.disp_bus = IDLE_WORD;
    repeat (3) @(negedge clk);
    checkOutput("resetDigits", 32'(scan.digits), 32'hFFFF);
    checkOutput("resetDps", 32'(scan.dps), 0);
    checkOutput("resetLeds", 32'(scan.leds), 0);
    checkOutput("resetPulses", 32'({scan.frame_valid, scan.frame_chg, scan.an_err, scan.timeout}), 0);
    checkOutput("resetSegErr", 32'(scan.seg_err), 0);
    checkOutput("resetMask", 32'(dut.mask), 0);
    rst = 1'b0;
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] scan 1234, first frame after reset");
    expectFrame(16'h1234, 4'b0100, 2'b10, 1'b1, 1'b0);
    scanFrame(segOf(1), segOf(2), segOf(3), segOf(4), 4'b0100, 2'b10, 8);
    waitDrain("frame1234");
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] repeat identical scan");
    expectFrame(16'h1234, 4'b0100, 2'b10, 1'b0, 1'b0);
    scanFrame(segOf(1), segOf(2), segOf(3), segOf(4), 4'b0100, 2'b10, 8);
    waitDrain("frameRepeat");
    checkOutput("digitsHeld", 32'(scan.digits), 32'h1234);
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] glitchy 3-cycle slots then normal scan");
    scanFrame(segOf(9), segOf(9), segOf(9), segOf(9), 4'b0000, 2'b01, 3);
    applyStimulus(IDLE_WORD, 6);
    checkOutput("maskAfterGlitch", 32'(dut.mask), 0);
    expectFrame(16'h5678, 4'b0000, 2'b01, 1'b1, 1'b0);
    scanFrame(segOf(5), segOf(6), segOf(7), segOf(8), 4'b0000, 2'b01, 8);
    waitDrain("frame5678");
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] bad segment pattern in slot 0, blank slot 3");
    expectFrame(16'hF89E, 4'b0000, 2'b00, 1'b1, 1'b1);
    scanFrame(7'h7F, 7'h00, segOf(9), 7'h55, 4'b0000, 2'b00, 8);
    waitDrain("frameBadSeg");
    checkOutput("segErrCleared", 32'(scan.seg_err), 0);
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] two anodes active mid-frame");
    expectFrame(16'h3210, 4'b0000, 2'b00, 1'b1, 1'b0);
    applyStimulus(mkWord(4'b1110, segOf(0), 1'b0, 2'b00), 8);
    applyStimulus(mkWord(4'b1100, segOf(8), 1'b0, 2'b00), 8);
    checkOutput("maskAfterAnErr", 32'(dut.mask), 32'b0001);
    applyStimulus(mkWord(4'b1101, segOf(1), 1'b0, 2'b00), 8);
    checkOutput("anErrOnce", 32'(anErrCount), 1);
    applyStimulus(mkWord(4'b1011, segOf(2), 1'b0, 2'b00), 8);
    applyStimulus(mkWord(4'b0111, segOf(3), 1'b0, 2'b00), 8);
    waitDrain("frame3210");
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] partial frame then timeout");
    applyStimulus(mkWord(4'b1110, segOf(4), 1'b0, 2'b00), 8);
    applyStimulus(mkWord(4'b1101, segOf(5), 1'b0, 2'b00), 8);
    scan.disp_bus = IDLE_WORD;
    n = 0;
    while (timeoutCount == 0 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeoutPulse", 32'(timeoutCount), 1);
    checkOutput("timeoutLatency", 32'(n == 65528 || n == 65529), 1);
    @(posedge clk);
    #1;
    checkOutput("digitsKeptAfterTimeout", 32'(scan.digits), 32'h3210);
    checkOutput("maskAfterTimeout", 32'(dut.mask), 0);

    $display("[TB] reset in the middle of a scan");
    applyStimulus(mkWord(4'b1110, segOf(7), 1'b1, 2'b11), 8);
    applyStimulus(mkWord(4'b1101, segOf(7), 1'b1, 2'b11), 4);
    checkOutput("maskBeforeReset", 32'(dut.mask), 32'b0001);
    rst = 1'b1;
    scan.disp_bus = IDLE_WORD;
    @(negedge clk);
    checkOutput("midResetDigits", 32'(scan.digits), 32'hFFFF);
    checkOutput("midResetDpsLeds", 32'({scan.dps, scan.leds}), 0);
    checkOutput("midResetMask", 32'(dut.mask), 0);
    checkOutput("midResetSegErr", 32'(scan.seg_err), 0);
    rst = 1'b0;
    applyStimulus(IDLE_WORD, 5);

    $display("[TB] all-blank frame equal to reset value");
    expectFrame(16'hFFFF, 4'b0000, 2'b11, 1'b1, 1'b0);
    scanFrame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 2'b11, 8);
    waitDrain("frameBlank");
    applyStimulus(IDLE_WORD, 5);

    checkOutput("anErrTotal", 32'(anErrCount), 1);
    checkOutput("timeoutTotal", 32'(timeoutCount), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
